// File: rtl/week6_pkg.sv
// Shared definitions for the week-6 encoder blocks: mode encodings, FSM state
// type and a clog2 helper for tools without $clog2.
package week6_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } enc_state_e;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/week6_rr_find.sv
// Combinational circular search: first set bit of vec at or above start,
// wrapping through index 0. start = 0 gives plain lowest-index priority.
module week6_rr_find
  import week6_pkg::*;
#(
  parameter int N = 4,
  parameter int W = clog2(N)
) (
  input  logic [N-1:0] vec,
  input  logic [W-1:0] start,
  output logic [W-1:0] idx,
  output logic         found
);

  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!found && vec[(int'(start) + k) % N]) begin
        idx   = W'((int'(start) + k) % N);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/week6_ex1_rr_encoder_reg.sv
// Registered N-to-log2(N) priority encoder with valid/ready on both sides,
// run-time fixed-priority or round-robin arbitration, zero and multi flags.
//
// state    | meaning
// ST_EMPTY | output register empty, out_valid = 0
// ST_FULL  | output register holds a result, out_valid = 1
module week6_ex1_rr_encoder_reg
  import week6_pkg::*;
#(
  parameter int N = 4,
  parameter int W = clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] in,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         rr_en,
  output logic [W-1:0] out,
  output logic         out_zero,
  output logic         out_multi,
  output logic         out_valid,
  input  logic         out_ready
);

  enc_state_e   state_q, state_d;
  logic [W-1:0] ptr_q, ptr_d;
  logic [W-1:0] out_q, out_d;
  logic         out_zero_q, out_zero_d;
  logic         out_multi_q, out_multi_d;

  logic [W-1:0] fix_idx, rr_idx, win_idx;
  logic         fix_found, rr_found, win_found;
  logic         full, ready, accept, drain, multi;

  week6_rr_find #(.N(N), .W(W)) u_find_fixed (
    .vec   (in),
    .start ('0),
    .idx   (fix_idx),
    .found (fix_found)
  );

  week6_rr_find #(.N(N), .W(W)) u_find_rr (
    .vec   (in),
    .start (ptr_q),
    .idx   (rr_idx),
    .found (rr_found)
  );

  always_comb begin
    full      = (state_q == ST_FULL);
    ready     = !full || out_ready;
    accept    = in_valid && ready;
    drain     = full && out_ready;
    win_idx   = (rr_en == MODE_RR) ? rr_idx : fix_idx;
    win_found = (rr_en == MODE_RR) ? rr_found : fix_found;
    // Clearing the lowest set bit leaves something only if two or more were set.
    multi     = |(in & (in - N'(1)));

    state_d     = state_q;
    ptr_d       = ptr_q;
    out_d       = out_q;
    out_zero_d  = out_zero_q;
    out_multi_d = out_multi_q;

    case (state_q)
      ST_EMPTY: if (accept) state_d = ST_FULL;
      ST_FULL:  if (drain && !accept) state_d = ST_EMPTY;
      default:  state_d = ST_EMPTY;
    endcase

    if (accept) begin
      out_d       = win_found ? win_idx : '0;
      out_zero_d  = !win_found;
      out_multi_d = multi;
      if (rr_en == MODE_RR && win_found) begin
        ptr_d = (win_idx == W'(N - 1)) ? '0 : win_idx + W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_EMPTY;
      ptr_q       <= '0;
      out_q       <= '0;
      out_zero_q  <= 1'b0;
      out_multi_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      out_q       <= out_d;
      out_zero_q  <= out_zero_d;
      out_multi_q <= out_multi_d;
    end
  end

  assign in_ready  = ready;
  assign out_valid = full;
  assign out       = out_q;
  assign out_zero  = out_zero_q;
  assign out_multi = out_multi_q;

endmodule

// File: tb/tb_week6_ex1_rr_encoder_reg.sv
// Self-checking bench: table of requests with expected results fed through a
// scoreboard, plus stall, reset-while-full and N=8 sequences.
module tb_week6_ex1_rr_encoder_reg;

  logic       clk;
  logic       rst;
  logic [3:0] in_vec;
  logic       in_valid, in_ready, rr_en;
  logic [1:0] out_idx;
  logic       out_zero, out_multi, out_valid, out_ready;

  logic [7:0] in8;
  logic       in_valid8, in_ready8, rr_en8;
  logic [2:0] out8;
  logic       out_zero8, out_multi8, out_valid8, out_ready8;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [1:0] o;
    logic       z;
    logic       m;
  } exp_t;

  typedef struct {
    bit         rst;
    logic [3:0] v;
    logic       rr;
    logic [1:0] o;
    logic       z;
    logic       m;
  } vec_t;

  exp_t sb[$];
  vec_t tbl[20];

  week6_ex1_rr_encoder_reg #(.N(4)) dut (
    .clk (clk), .rst (rst), .in (in_vec), .in_valid (in_valid), .in_ready (in_ready),
    .rr_en (rr_en), .out (out_idx), .out_zero (out_zero), .out_multi (out_multi),
    .out_valid (out_valid), .out_ready (out_ready)
  );

  week6_ex1_rr_encoder_reg #(.N(8)) dut8 (
    .clk (clk), .rst (rst), .in (in8), .in_valid (in_valid8), .in_ready (in_ready8),
    .rr_en (rr_en8), .out (out8), .out_zero (out_zero8), .out_multi (out_multi8),
    .out_valid (out_valid8), .out_ready (out_ready8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Pops one expected result for every handshake on the output side.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_output", 32'(out_idx), 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_out", 32'(out_idx), 32'(e.o));
        chk("sb_zero", 32'(out_zero), 32'(e.z));
        chk("sb_multi", 32'(out_multi), 32'(e.m));
      end
    end
  end

  // Starts and ends at posedge+1.
  task automatic send(input logic [3:0] v, input logic rr, input exp_t e,
                      input bit push, output int waited);
    logic acc;
    in_vec   = v;
    rr_en    = rr;
    in_valid = 1'b1;
    waited   = 0;
    acc      = 1'b0;
    forever begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      if (acc) break;
      waited++;
      if (waited > 20) begin
        chk("accept_timeout", 32'(waited), 32'd0);
        break;
      end
    end
    if (acc && push) sb.push_back(e);
    in_valid = 1'b0;
  endtask

  task automatic drain_wait();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 30) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_empty", 32'(sb.size()), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out", 32'(out_idx), 32'd0);
    chk("rst_zero", 32'(out_zero), 32'd0);
    chk("rst_multi", 32'(out_multi), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic send8(input logic [7:0] v, input logic rr,
                       input logic [2:0] o, input logic m);
    in8       = v;
    rr_en8    = rr;
    in_valid8 = 1'b1;
    @(negedge clk);
    chk("n8_in_ready", 32'(in_ready8), 32'd1);
    @(posedge clk);
    #1;
    in_valid8 = 1'b0;
    @(negedge clk);
    chk("n8_valid", 32'(out_valid8), 32'd1);
    chk("n8_out", 32'(out8), 32'(o));
    chk("n8_multi", 32'(out_multi8), 32'(m));
    @(posedge clk);
    #1;
  endtask

  initial begin
    int w;
    rst = 1'b1; in_vec = '0; in_valid = 1'b0; rr_en = 1'b0; out_ready = 1'b1;
    in8 = '0; in_valid8 = 1'b0; rr_en8 = 1'b0; out_ready8 = 1'b1;

    //           rst  in       rr    out   z     m
    tbl[0]  = '{1, 4'b0001, 1'b0, 2'd0, 1'b0, 1'b0};
    tbl[1]  = '{0, 4'b0010, 1'b0, 2'd1, 1'b0, 1'b0};
    tbl[2]  = '{0, 4'b0100, 1'b0, 2'd2, 1'b0, 1'b0};
    tbl[3]  = '{0, 4'b1000, 1'b0, 2'd3, 1'b0, 1'b0};
    tbl[4]  = '{0, 4'b1010, 1'b0, 2'd1, 1'b0, 1'b1};
    tbl[5]  = '{0, 4'b0000, 1'b0, 2'd0, 1'b1, 1'b0};
    tbl[6]  = '{0, 4'b1111, 1'b1, 2'd0, 1'b0, 1'b1};
    tbl[7]  = '{0, 4'b1111, 1'b1, 2'd1, 1'b0, 1'b1};
    tbl[8]  = '{0, 4'b1111, 1'b1, 2'd2, 1'b0, 1'b1};
    tbl[9]  = '{0, 4'b1111, 1'b1, 2'd3, 1'b0, 1'b1};
    tbl[10] = '{0, 4'b1111, 1'b1, 2'd0, 1'b0, 1'b1};
    tbl[11] = '{1, 4'b1001, 1'b1, 2'd0, 1'b0, 1'b1};
    tbl[12] = '{0, 4'b0000, 1'b1, 2'd0, 1'b1, 1'b0};
    tbl[13] = '{0, 4'b1001, 1'b1, 2'd3, 1'b0, 1'b1};
    tbl[14] = '{0, 4'b1001, 1'b1, 2'd0, 1'b0, 1'b1};
    tbl[15] = '{0, 4'b0110, 1'b0, 2'd1, 1'b0, 1'b1};
    tbl[16] = '{0, 4'b0011, 1'b1, 2'd1, 1'b0, 1'b1};
    tbl[17] = '{0, 4'b0101, 1'b1, 2'd2, 1'b0, 1'b1};
    tbl[18] = '{0, 4'b0001, 1'b1, 2'd0, 1'b0, 1'b0};
    tbl[19] = '{0, 4'b1100, 1'b1, 2'd2, 1'b0, 1'b1};

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    for (int i = 0; i < 20; i++) begin
      if (tbl[i].rst) begin
        drain_wait();
        do_reset();
      end
      send(tbl[i].v, tbl[i].rr, '{o: tbl[i].o, z: tbl[i].z, m: tbl[i].m}, 1'b1, w);
      chk("b2b_no_wait", 32'(w), 32'd0);
    end
    drain_wait();

    // Backpressure: result held for three cycles while a new request waits.
    do_reset();
    send(4'b0001, 1'b0, '{o: 2'd0, z: 1'b0, m: 1'b0}, 1'b1, w);
    out_ready = 1'b0;
    fork
      begin
        send(4'b0010, 1'b0, '{o: 2'd1, z: 1'b0, m: 1'b0}, 1'b1, w);
      end
      begin
        repeat (3) begin
          @(negedge clk);
          chk("stall_in_ready", 32'(in_ready), 32'd0);
          chk("stall_valid", 32'(out_valid), 32'd1);
          chk("stall_out", 32'(out_idx), 32'd0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    chk("stall_wait_cycles", 32'(w), 32'd3);
    drain_wait();

    // Reset while FULL discards the held result and rewinds the pointer.
    out_ready = 1'b0;
    send(4'b1111, 1'b1, '{o: 2'd0, z: 1'b0, m: 1'b1}, 1'b0, w);
    @(negedge clk);
    chk("held_valid", 32'(out_valid), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("rst_full_valid", 32'(out_valid), 32'd0);
    chk("rst_full_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    send(4'b1111, 1'b1, '{o: 2'd0, z: 1'b0, m: 1'b1}, 1'b1, w);
    drain_wait();

    // Scale check at N=8, including round-robin wrap from index 7.
    send8(8'h80, 1'b0, 3'd7, 1'b0);
    send8(8'h81, 1'b1, 3'd0, 1'b1);
    send8(8'h81, 1'b1, 3'd7, 1'b1);
    send8(8'h81, 1'b1, 3'd0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
